memory_write_arbiter: RTL and testbench

Sequencer and arbiter for the single write port of the tri-port frame memory. It shares that port between two write requesters (for example, pixel writer and host) using round-robin valid/ready handshakes. It also provides a clear engine that sweeps every address with a fill value. The block runs in the memory's write clock domain and drives the memory's `data_in`, `write_address_in` and `memory_wr_in` directly from registers.

---
 rtl/memory_write_arbiter_pkg.sv | 11 +
 rtl/memory_write_arbiter_if.sv | 39 +++
 rtl/memory_write_arbiter_round_robin_picker.sv | 22 ++
 rtl/memory_write_arbiter.sv | 95 +++++++++
 tb/tb_memory_write_arbiter.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/memory_write_arbiter_pkg.sv
// rtl/memory_write_arbiter_pkg.sv - shared types and constants for the frame-memory write arbiter
package memory_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_CLEAR = 1'b1
  } arbiter_state_t;

  localparam int NUM_REQUESTERS = 2;

endpackage

// File: rtl/memory_write_arbiter_if.sv
// rtl/memory_write_arbiter_if.sv - requester, clear and memory-side signals of the write arbiter
interface memory_write_arbiter_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 5
);

  logic                     clear_start_in;
  logic [DATA_WIDTH-1:0]    clear_value_in;
  logic                     clear_busy_out;
  logic                     req0_valid_in;
  logic [ADDRESS_WIDTH-1:0] req0_address_in;
  logic [DATA_WIDTH-1:0]    req0_data_in;
  logic                     req0_ready_out;
  logic                     req1_valid_in;
  logic [ADDRESS_WIDTH-1:0] req1_address_in;
  logic [DATA_WIDTH-1:0]    req1_data_in;
  logic                     req1_ready_out;
  logic [ADDRESS_WIDTH-1:0] write_address_out;
  logic [DATA_WIDTH-1:0]    data_out;
  logic                     memory_wr_out;
  logic                     grant_out;

  modport slave (
    input  clear_start_in, clear_value_in,
    input  req0_valid_in, req0_address_in, req0_data_in,
    input  req1_valid_in, req1_address_in, req1_data_in,
    output clear_busy_out, req0_ready_out, req1_ready_out,
    output write_address_out, data_out, memory_wr_out, grant_out
  );

  modport master (
    output clear_start_in, clear_value_in,
    output req0_valid_in, req0_address_in, req0_data_in,
    output req1_valid_in, req1_address_in, req1_data_in,
    input  clear_busy_out, req0_ready_out, req1_ready_out,
    input  write_address_out, data_out, memory_wr_out, grant_out
  );

endinterface

// File: rtl/memory_write_arbiter_round_robin_picker.sv
// rtl/memory_write_arbiter_round_robin_picker.sv - combinational two-way round-robin grant selection
module round_robin_picker
  import memory_arbiter_pkg::*;
(
  input  logic [NUM_REQUESTERS-1:0] valids,
  input  logic                      pointer,
  output logic                      grant_index,
  output logic                      grant_valid
);

  // A lone requester wins regardless of the pointer; the pointer only breaks ties.
  always_comb begin
    grant_valid = |valids;
    grant_index = pointer;
    if (valids == 2'b01) begin
      grant_index = 1'b0;
    end else if (valids == 2'b10) begin
      grant_index = 1'b1;
    end
  end

endmodule

// File: rtl/memory_write_arbiter.sv
// rtl/memory_write_arbiter.sv - round-robin write-port arbiter with full-memory clear engine
module memory_write_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 5
) (
  input logic             clock_in,
  input logic             reset_in,
  memory_write_arbiter_if.slave bus
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = {ADDRESS_WIDTH{1'b1}};

  arbiter_state_t           state;
  logic                     pointer;
  logic [ADDRESS_WIDTH-1:0] clear_counter;
  logic [DATA_WIDTH-1:0]    fill_value;
  logic                     final_clear_write;
  logic [ADDRESS_WIDTH-1:0] write_address_reg;
  logic [DATA_WIDTH-1:0]    data_reg;
  logic                     memory_wr_reg;
  logic                     grant_reg;

  logic                     grant_index;
  logic                     grant_valid;
  logic                     accept_window;
  logic                     handshake;

  round_robin_picker picker (
    .valids      ({bus.req1_valid_in, bus.req0_valid_in}),
    .pointer     (pointer),
    .grant_index (grant_index),
    .grant_valid (grant_valid)
  );

  // Requests stay blocked through the final clear write so acceptance lines up with busy dropping.
  assign accept_window = (state == ARB_IDLE) && !final_clear_write && !bus.clear_start_in;
  assign handshake     = accept_window && grant_valid;

  assign bus.req0_ready_out    = handshake && (grant_index == 1'b0);
  assign bus.req1_ready_out    = handshake && (grant_index == 1'b1);
  assign bus.clear_busy_out    = (state == ARB_CLEAR) || final_clear_write;
  assign bus.write_address_out = write_address_reg;
  assign bus.data_out          = data_reg;
  assign bus.memory_wr_out     = memory_wr_reg;
  assign bus.grant_out         = grant_reg;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state             <= ARB_IDLE;
      pointer           <= 1'b0;
      clear_counter     <= '0;
      fill_value        <= '0;
      final_clear_write <= 1'b0;
      write_address_reg <= '0;
      data_reg          <= '0;
      memory_wr_reg     <= 1'b0;
      grant_reg         <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          final_clear_write <= 1'b0;
          memory_wr_reg     <= 1'b0;
          if (!final_clear_write && bus.clear_start_in) begin
            state         <= ARB_CLEAR;
            clear_counter <= '0;
            fill_value    <= bus.clear_value_in;
          end else if (handshake) begin
            write_address_reg <= grant_index ? bus.req1_address_in : bus.req0_address_in;
            data_reg          <= grant_index ? bus.req1_data_in : bus.req0_data_in;
            memory_wr_reg     <= 1'b1;
            grant_reg         <= grant_index;
            pointer           <= ~grant_index;
          end
        end
        ARB_CLEAR: begin
          write_address_reg <= clear_counter;
          data_reg          <= fill_value;
          memory_wr_reg     <= 1'b1;
          clear_counter     <= clear_counter + 1'b1;
          if (clear_counter == LAST_ADDRESS) begin
            state             <= ARB_IDLE;
            final_clear_write <= 1'b1;
          end
        end
        default: begin
          state         <= ARB_IDLE;
          memory_wr_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_write_arbiter.sv
// tb/tb_memory_write_arbiter.sv - directed self-checking bench for memory_write_arbiter
module tb_memory_write_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] mem [0:31];

  always #5 clk = ~clk;

  memory_write_arbiter_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(5)) bus ();

  memory_write_arbiter #(.DATA_WIDTH(16), .ADDRESS_WIDTH(5)) dut (
    .clock_in (clk),
    .reset_in (rst),
    .bus      (bus.slave)
  );

  // Stand-in for the frame memory: captures every registered write.
  always @(posedge clk) begin
    if (bus.memory_wr_out) mem[bus.write_address_out] <= bus.data_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.clear_start_in  = 1'b0;
    bus.clear_value_in  = '0;
    bus.req0_valid_in   = 1'b0;
    bus.req0_address_in = '0;
    bus.req0_data_in    = '0;
    bus.req1_valid_in   = 1'b0;
    bus.req1_address_in = '0;
    bus.req1_data_in    = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_wr", bus.memory_wr_out, 0);
    chk("reset_addr", bus.write_address_out, 0);
    chk("reset_data", bus.data_out, 0);
    chk("reset_grant", bus.grant_out, 0);
    chk("reset_busy", bus.clear_busy_out, 0);
    chk("reset_rdy0", bus.req0_ready_out, 0);
    chk("reset_rdy1", bus.req1_ready_out, 0);

    // Single request from requester 0
    bus.req0_valid_in = 1'b1; bus.req0_address_in = 5'd3; bus.req0_data_in = 16'h0001;
    #1;
    chk("single0_rdy0", bus.req0_ready_out, 1);
    chk("single0_rdy1", bus.req1_ready_out, 0);
    tick();
    bus.req0_valid_in = 1'b0;
    chk("single0_wr", bus.memory_wr_out, 1);
    chk("single0_addr", bus.write_address_out, 3);
    chk("single0_data", bus.data_out, 16'h0001);
    chk("single0_grant", bus.grant_out, 0);
    tick();
    chk("single0_pulse_end", bus.memory_wr_out, 0);
    chk("single0_addr_hold", bus.write_address_out, 3);

    // Lone requester 1 wins even though the pointer now names it anyway; pointer returns to 0
    bus.req1_valid_in = 1'b1; bus.req1_address_in = 5'd7; bus.req1_data_in = 16'hBEEF;
    #1;
    chk("single1_rdy1", bus.req1_ready_out, 1);
    tick();
    bus.req1_valid_in = 1'b0;
    chk("single1_wr", bus.memory_wr_out, 1);
    chk("single1_addr", bus.write_address_out, 7);
    chk("single1_data", bus.data_out, 16'hBEEF);
    chk("single1_grant", bus.grant_out, 1);

    // Both valid for four cycles: strict alternation starting at requester 0
    bus.req0_valid_in = 1'b1; bus.req0_address_in = 5'd4; bus.req0_data_in = 16'h00A0;
    bus.req1_valid_in = 1'b1; bus.req1_address_in = 5'd9; bus.req1_data_in = 16'h00B1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_rdy0", i), bus.req0_ready_out, (i % 2 == 0));
      chk($sformatf("rr%0d_rdy1", i), bus.req1_ready_out, (i % 2 == 1));
      tick();
      chk($sformatf("rr%0d_wr", i), bus.memory_wr_out, 1);
      chk($sformatf("rr%0d_grant", i), bus.grant_out, i % 2);
      chk($sformatf("rr%0d_addr", i), bus.write_address_out, (i % 2 == 0) ? 4 : 9);
      chk($sformatf("rr%0d_data", i), bus.data_out, (i % 2 == 0) ? 16'h00A0 : 16'h00B1);
    end
    bus.req0_valid_in = 1'b0;
    bus.req1_valid_in = 1'b0;
    tick();
    chk("rr_idle_wr", bus.memory_wr_out, 0);

    // Clear while requester 1 is waiting: clear wins
    bus.req1_valid_in = 1'b1; bus.req1_address_in = 5'd20; bus.req1_data_in = 16'h1234;
    bus.clear_start_in = 1'b1; bus.clear_value_in = 16'h00FF;
    #1;
    chk("clr_start_rdy1", bus.req1_ready_out, 0);
    chk("clr_start_rdy0", bus.req0_ready_out, 0);
    tick();
    bus.clear_start_in = 1'b0;
    chk("clr_first_busy", bus.clear_busy_out, 1);
    chk("clr_first_wr", bus.memory_wr_out, 0);
    for (int k = 0; k < 32; k++) begin
      tick();
      if (k == 10) begin
        bus.clear_start_in = 1'b1;
        bus.clear_value_in = 16'h5555;
      end else begin
        bus.clear_start_in = 1'b0;
      end
      chk($sformatf("clr%0d_wr", k), bus.memory_wr_out, 1);
      chk($sformatf("clr%0d_addr", k), bus.write_address_out, k);
      chk($sformatf("clr%0d_data", k), bus.data_out, 16'h00FF);
      chk($sformatf("clr%0d_busy", k), bus.clear_busy_out, 1);
      chk($sformatf("clr%0d_rdy1", k), bus.req1_ready_out, 0);
    end
    bus.clear_start_in = 1'b0;
    tick();
    chk("clr_done_wr", bus.memory_wr_out, 0);
    chk("clr_done_busy", bus.clear_busy_out, 0);
    chk("clr_done_rdy1", bus.req1_ready_out, 1);
    tick();
    bus.req1_valid_in = 1'b0;
    chk("post_clr_wr", bus.memory_wr_out, 1);
    chk("post_clr_addr", bus.write_address_out, 20);
    chk("post_clr_data", bus.data_out, 16'h1234);
    chk("post_clr_grant", bus.grant_out, 1);

    // Reset aborts a clear at address 10
    bus.clear_start_in = 1'b1; bus.clear_value_in = 16'hAAAA;
    tick();
    bus.clear_start_in = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      tick();
      chk($sformatf("abort%0d_addr", k), bus.write_address_out, k);
    end
    rst = 1'b1;
    tick();
    chk("abort_wr", bus.memory_wr_out, 0);
    chk("abort_busy", bus.clear_busy_out, 0);
    chk("abort_grant", bus.grant_out, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("abort_quiet%0d_wr", k), bus.memory_wr_out, 0);
      chk($sformatf("abort_quiet%0d_busy", k), bus.clear_busy_out, 0);
    end

    // Full clear to zero, then one host write, then read back the memory image
    bus.clear_start_in = 1'b1; bus.clear_value_in = 16'h0000;
    tick();
    bus.clear_start_in = 1'b0;
    for (int k = 0; k < 33; k++) tick();
    chk("mem_clr_busy", bus.clear_busy_out, 0);
    bus.req0_valid_in = 1'b1; bus.req0_address_in = 5'd15; bus.req0_data_in = 16'hFFFF;
    #1;
    chk("mem_rdy0", bus.req0_ready_out, 1);
    tick();
    bus.req0_valid_in = 1'b0;
    tick();
    chk("mem_port_a_15", mem[15], 16'hFFFF);
    chk("mem_port_b_16", mem[16], 16'h0000);
    chk("mem_addr0", mem[0], 16'h0000);
    chk("mem_addr31", mem[31], 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
